// File: rtl/cv32e40n_obi_arbiter.sv
// Two-master, one-slave pipelined OBI arbiter: the CPU LSU (M1) and the NVPE (M2) share
// one data port, with in-order response routing and a bound on CPU starvation.
module cv32e40n_obi_arbiter #(
  parameter int unsigned NUM_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  output logic        s_req_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s_rdata_i,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,

  input  logic        m2_req_i,
  output logic        m2_gnt_o,
  output logic        m2_rvalid_o,
  input  logic [31:0] m2_addr_i,
  input  logic        m2_we_i,
  input  logic [3:0]  m2_be_i,
  input  logic [31:0] m2_wdata_i,
  output logic [31:0] m2_rdata_o,

  output logic        busy_o,
  output logic        proto_err_o
);

  localparam int unsigned CNT_W = $clog2(NUM_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(NUM_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_OUTSTANDING - 1);
  localparam logic [7:0]       STARVE_MAX = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    LOCK_M1 = 2'd1,
    LOCK_M2 = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PTR_W-1:0]           wptr_q, wptr_d;
  logic [PTR_W-1:0]           rptr_q, rptr_d;
  logic [NUM_OUTSTANDING-1:0] id_q, id_d;
  logic [7:0]                 starve_q, starve_d;
  logic                       proto_err_q, proto_err_d;

  logic sel_m2_s;
  logic sel_req_s;
  logic full_s;
  logic empty_s;
  logic hs_s;
  logic pop_s;
  logic head_m2_s;

  // Master selection: free in ARB, pinned to the presented master while locked
  always_comb begin
    sel_m2_s = 1'b0;
    case (state_q)
      ARB: begin
        case ({m1_req_i, m2_req_i})
          2'b01:   sel_m2_s = 1'b1;
          2'b11:   sel_m2_s = (starve_q != STARVE_MAX);
          default: sel_m2_s = 1'b0;
        endcase
      end
      LOCK_M1: sel_m2_s = 1'b0;
      LOCK_M2: sel_m2_s = 1'b1;
      default: sel_m2_s = 1'b0;
    endcase
  end

  assign sel_req_s = sel_m2_s ? m2_req_i : m1_req_i;
  // Full uses the registered count only; a same-cycle pop does not free a slot
  assign full_s    = (cnt_q == CNT_MAX);
  assign empty_s   = (cnt_q == {CNT_W{1'b0}});
  assign s_req_o   = sel_req_s & ~full_s;
  assign hs_s      = s_req_o & s_gnt_i;
  assign pop_s     = s_rvalid_i & ~empty_s;
  assign head_m2_s = id_q[rptr_q];

  assign s_addr_o  = sel_m2_s ? m2_addr_i  : m1_addr_i;
  assign s_we_o    = sel_m2_s ? m2_we_i    : m1_we_i;
  assign s_be_o    = sel_m2_s ? m2_be_i    : m1_be_i;
  assign s_wdata_o = sel_m2_s ? m2_wdata_i : m1_wdata_i;

  assign m1_gnt_o    = hs_s & ~sel_m2_s;
  assign m2_gnt_o    = hs_s &  sel_m2_s;
  assign m1_rvalid_o = pop_s & ~head_m2_s;
  assign m2_rvalid_o = pop_s &  head_m2_s;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : 32'h0000_0000;
  assign m2_rdata_o  = m2_rvalid_o ? s_rdata_i : 32'h0000_0000;

  assign busy_o      = ~empty_s;
  assign proto_err_o = proto_err_q;

  // Address-phase FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB: begin
        if (s_req_o && !s_gnt_i) begin
          state_d = sel_m2_s ? LOCK_M2 : LOCK_M1;
        end else begin
          state_d = ARB;
        end
      end
      LOCK_M1: begin
        if (hs_s || !m1_req_i) begin
          state_d = ARB;
        end else begin
          state_d = LOCK_M1;
        end
      end
      LOCK_M2: begin
        if (hs_s || !m2_req_i) begin
          state_d = ARB;
        end else begin
          state_d = LOCK_M2;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // ID FIFO, outstanding count and sticky protocol error
  always_comb begin
    id_d        = id_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    proto_err_d = proto_err_q | (s_rvalid_i & empty_s);
    if (hs_s) begin
      id_d[wptr_q] = sel_m2_s;
      wptr_d       = (wptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = (rptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({hs_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Starvation counter: consecutive M2 wins while M1 waits
  always_comb begin
    starve_d = starve_q;
    if (!m1_req_i || (hs_s && !sel_m2_s)) begin
      starve_d = 8'd0;
    end else if (hs_s && sel_m2_s && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 8'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB;
      cnt_q       <= {CNT_W{1'b0}};
      wptr_q      <= {PTR_W{1'b0}};
      rptr_q      <= {PTR_W{1'b0}};
      id_q        <= {NUM_OUTSTANDING{1'b0}};
      starve_q    <= 8'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      id_q        <= id_d;
      starve_q    <= starve_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_cv32e40n_obi_arbiter.sv
// Directed bench for cv32e40n_obi_arbiter (NUM_OUTSTANDING=2, STARVE_LIMIT=8).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_cv32e40n_obi_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s_req_o, s_gnt_i, s_rvalid_i;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic        m1_req_i, m1_gnt_o, m1_rvalid_o, m1_we_i;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_be_i;
  logic        m2_req_i, m2_gnt_o, m2_rvalid_o, m2_we_i;
  logic [31:0] m2_addr_i, m2_wdata_i, m2_rdata_o;
  logic [3:0]  m2_be_i;
  logic        busy_o, proto_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  cv32e40n_obi_arbiter #(.NUM_OUTSTANDING(2), .STARVE_LIMIT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o),
    .m2_req_i(m2_req_i), .m2_gnt_o(m2_gnt_o), .m2_rvalid_o(m2_rvalid_o),
    .m2_addr_i(m2_addr_i), .m2_we_i(m2_we_i), .m2_be_i(m2_be_i),
    .m2_wdata_i(m2_wdata_i), .m2_rdata_o(m2_rdata_o),
    .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m1_req_i   = 1'b0;
    m2_req_i   = 1'b0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       exp_m1;
    logic       prev_m1;
    logic [9:0] sreq_exp;
    logic [9:0] rv_exp;

    idle_inputs();
    m1_addr_i = 32'h0000_0100; m1_we_i = 1'b0; m1_be_i = 4'hF; m1_wdata_i = 32'h1111_1111;
    m2_addr_i = 32'h0000_0200; m2_we_i = 1'b1; m2_be_i = 4'h3; m2_wdata_i = 32'h0000_CAFE;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset / idle state
    #1;
    check("rst_busy",      32'(busy_o),      32'd0);
    check("rst_proto_err", 32'(proto_err_o), 32'd0);
    check("rst_s_req",     32'(s_req_o),     32'd0);
    check("rst_m1_gnt",    32'(m1_gnt_o),    32'd0);
    check("rst_m2_gnt",    32'(m2_gnt_o),    32'd0);
    check("rst_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
    check("rst_m2_rvalid", 32'(m2_rvalid_o), 32'd0);
    check("rst_m1_rdata",  m1_rdata_o,       32'd0);
    check("rst_m2_rdata",  m2_rdata_o,       32'd0);

    // Single M1 read
    @(negedge clk_i); m1_req_i = 1'b1; s_gnt_i = 1'b1; #1;
    check("rd_s_req",  32'(s_req_o),  32'd1);
    check("rd_m1_gnt", 32'(m1_gnt_o), 32'd1);
    check("rd_m2_gnt", 32'(m2_gnt_o), 32'd0);
    check("rd_addr",   s_addr_o,      32'h0000_0100);
    check("rd_be",     32'(s_be_o),   32'hF);
    check("rd_busy0",  32'(busy_o),   32'd0);
    @(negedge clk_i); idle_inputs(); s_rvalid_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF; #1;
    check("rd_m1_rvalid", 32'(m1_rvalid_o), 32'd1);
    check("rd_m1_rdata",  m1_rdata_o,       32'hDEAD_BEEF);
    check("rd_m2_rvalid", 32'(m2_rvalid_o), 32'd0);
    check("rd_m2_rdata",  m2_rdata_o,       32'd0);
    check("rd_busy1",     32'(busy_o),      32'd1);
    @(negedge clk_i); idle_inputs(); #1;
    check("rd_busy2",     32'(busy_o),      32'd0);

    // M2 presented, gnt withheld 3 cycles, M1 joins in cycle 1
    @(negedge clk_i); m2_req_i = 1'b1; #1;
    check("lk2_c0_addr",  s_addr_o,         32'h0000_0200);
    check("lk2_c0_we",    32'(s_we_o),      32'd1);
    check("lk2_c0_wdata", s_wdata_o,        32'h0000_CAFE);
    check("lk2_c0_sreq",  32'(s_req_o),     32'd1);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk_i); m1_req_i = 1'b1; #1;
      check("lk2_hold_addr", s_addr_o,      32'h0000_0200);
      check("lk2_hold_m1g",  32'(m1_gnt_o), 32'd0);
      check("lk2_hold_m2g",  32'(m2_gnt_o), 32'd0);
    end
    @(negedge clk_i); s_gnt_i = 1'b1; #1;
    check("lk2_c3_m2g",  32'(m2_gnt_o), 32'd1);
    check("lk2_c3_m1g",  32'(m1_gnt_o), 32'd0);
    check("lk2_c3_addr", s_addr_o,      32'h0000_0200);
    @(negedge clk_i); m2_req_i = 1'b0; #1;
    check("lk2_c4_m1g",  32'(m1_gnt_o), 32'd1);
    check("lk2_c4_addr", s_addr_o,      32'h0000_0100);
    @(negedge clk_i); idle_inputs(); s_rvalid_i = 1'b1; s_rdata_i = 32'h0000_00B2; #1;
    check("lk2_r0_m2v", 32'(m2_rvalid_o), 32'd1);
    check("lk2_r0_m2d", m2_rdata_o,       32'h0000_00B2);
    check("lk2_r0_m1v", 32'(m1_rvalid_o), 32'd0);
    @(negedge clk_i); s_rdata_i = 32'h0000_00B1; #1;
    check("lk2_r1_m1v", 32'(m1_rvalid_o), 32'd1);
    check("lk2_r1_m1d", m1_rdata_o,       32'h0000_00B1);
    check("lk2_r1_m2d", m2_rdata_o,       32'd0);

    // M1 presented without gnt, then M2 joins: the lock must keep M1 selected
    @(negedge clk_i); idle_inputs(); m1_req_i = 1'b1; #1;
    check("lk1_c0_sreq", 32'(s_req_o), 32'd1);
    @(negedge clk_i); m2_req_i = 1'b1; #1;
    check("lk1_c1_addr", s_addr_o,      32'h0000_0100);
    check("lk1_c1_m2g",  32'(m2_gnt_o), 32'd0);
    @(negedge clk_i); s_gnt_i = 1'b1; #1;
    check("lk1_c2_m1g",  32'(m1_gnt_o), 32'd1);
    check("lk1_c2_m2g",  32'(m2_gnt_o), 32'd0);
    @(negedge clk_i); m1_req_i = 1'b0; #1;
    check("lk1_c3_m2g",  32'(m2_gnt_o), 32'd1);
    @(negedge clk_i); idle_inputs(); s_rvalid_i = 1'b1; s_rdata_i = 32'h0000_00A1; #1;
    check("lk1_r0_m1v", 32'(m1_rvalid_o), 32'd1);
    check("lk1_r0_m1d", m1_rdata_o,       32'h0000_00A1);
    @(negedge clk_i); s_rdata_i = 32'h0000_00A2; #1;
    check("lk1_r1_m2v", 32'(m2_rvalid_o), 32'd1);
    check("lk1_r1_m1v", 32'(m1_rvalid_o), 32'd0);
    @(negedge clk_i); idle_inputs(); #1;
    check("lk1_busy", 32'(busy_o), 32'd0);

    // Starvation bound: 8 M2 wins then one M1 win, repeating; responses next cycle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      m1_req_i = 1'b1; m2_req_i = 1'b1; s_gnt_i = 1'b1;
      s_rvalid_i = (i > 0); s_rdata_i = 32'h1000 + 32'(i);
      #1;
      exp_m1 = ((i % 9) == 8);
      check("stv_m1_gnt", 32'(m1_gnt_o), 32'(exp_m1));
      check("stv_m2_gnt", 32'(m2_gnt_o), 32'(!exp_m1));
      check("stv_addr",   s_addr_o, exp_m1 ? 32'h0000_0100 : 32'h0000_0200);
      if (i > 0) begin
        prev_m1 = (((i - 1) % 9) == 8);
        check("stv_m1_rv", 32'(m1_rvalid_o), 32'(prev_m1));
        check("stv_m2_rd", m2_rdata_o, prev_m1 ? 32'd0 : 32'h1000 + 32'(i));
      end
    end
    @(negedge clk_i); idle_inputs(); s_rvalid_i = 1'b1; s_rdata_i = 32'h0000_2000; #1;
    check("stv_last_m2v", 32'(m2_rvalid_o), 32'd1);
    check("stv_last_m2d", m2_rdata_o,       32'h0000_2000);
    @(negedge clk_i); idle_inputs(); #1;
    check("stv_busy", 32'(busy_o), 32'd0);

    // Outstanding limit: grant every cycle, first rvalid at cycle 5
    sreq_exp = 10'b00_0100_0011;
    rv_exp   = 10'b01_1010_0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      m1_req_i   = (c < 7);
      s_gnt_i    = 1'b1;
      s_rvalid_i = rv_exp[c];
      s_rdata_i  = 32'h3000 + 32'(c);
      #1;
      check("out_sreq",   32'(s_req_o),     32'(sreq_exp[c]));
      check("out_m1_rv",  32'(m1_rvalid_o), 32'(rv_exp[c]));
      check("out_cnt_le", 32'(dut.cnt_q <= 2), 32'd1);
    end
    @(negedge clk_i); idle_inputs(); #1;
    check("out_busy", 32'(busy_o), 32'd0);

    // Push and pop in the same cycle at count 1
    @(negedge clk_i); m1_req_i = 1'b1; s_gnt_i = 1'b1; #1;
    check("pp_m1g", 32'(m1_gnt_o), 32'd1);
    @(negedge clk_i); m1_req_i = 1'b0; m2_req_i = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = 32'h0000_0C01; #1;
    check("pp_m2g",  32'(m2_gnt_o),    32'd1);
    check("pp_m1rv", 32'(m1_rvalid_o), 32'd1);
    check("pp_m1rd", m1_rdata_o,       32'h0000_0C01);
    @(negedge clk_i); m2_req_i = 1'b0; s_gnt_i = 1'b0; s_rdata_i = 32'h0000_0C02; #1;
    check("pp_cnt",  32'(dut.cnt_q),   32'd1);
    check("pp_m2rv", 32'(m2_rvalid_o), 32'd1);
    check("pp_m2rd", m2_rdata_o,       32'h0000_0C02);
    check("pp_m1rv0", 32'(m1_rvalid_o), 32'd0);
    @(negedge clk_i); idle_inputs(); #1;
    check("pp_busy", 32'(busy_o), 32'd0);

    // Reset mid-transaction, then a spurious response
    @(negedge clk_i); m1_req_i = 1'b1; s_gnt_i = 1'b1; #1;
    check("rr_m1g", 32'(m1_gnt_o), 32'd1);
    @(negedge clk_i); idle_inputs(); rst_ni = 1'b0; #1;
    check("rr_busy_rst", 32'(busy_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i); s_rvalid_i = 1'b1; s_rdata_i = 32'h0000_0055; #1;
    check("sp_m1rv", 32'(m1_rvalid_o), 32'd0);
    check("sp_m2rv", 32'(m2_rvalid_o), 32'd0);
    check("sp_m1rd", m1_rdata_o,       32'd0);
    check("sp_perr0", 32'(proto_err_o), 32'd0);
    @(negedge clk_i); idle_inputs(); #1;
    check("sp_perr1", 32'(proto_err_o), 32'd1);
    check("sp_busy",  32'(busy_o),      32'd0);
    repeat (3) @(negedge clk_i);
    #1;
    check("sp_perr_sticky", 32'(proto_err_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40n_obi_arbiter.md
# cv32e40n_obi_arbiter

Pipelined two-master, one-slave OBI arbiter that shares the core's single data-memory port between the CPU load/store unit (M1) and the NVPE vector engine (M2). Unlike a one-transaction-at-a-time mux, it allows up to NUM_OUTSTANDING granted transactions in flight. It routes each response back to its issuing master through an in-order ID FIFO, and bounds CPU starvation under sustained vector traffic. It sits between both masters and the data memory interface.

## Interface
- NUM_OUTSTANDING, 2, max granted-but-unanswered transactions (1..8); sets the ID FIFO depth.
- STARVE_LIMIT, 8, consecutive M2 handshakes allowed while M1 is requesting before M1 is forced (1..255).
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- s_req_o / s_gnt_i / s_rvalid_i  out/in/in  1  slave handshake
- s_addr_o  out  32; s_we_o  out  1; s_be_o  out  4; s_wdata_o  out  32; s_rdata_i  in  32  slave payload
- m1_req_i / m1_gnt_o / m1_rvalid_o  in/out/out  1  CPU handshake
- m1_addr_i  in  32; m1_we_i  in  1; m1_be_i  in  4; m1_wdata_i  in  32; m1_rdata_o  out  32  CPU payload
- m2_*  same set as m1_*  NVPE port
- busy_o  out  1  high when outstanding count is nonzero
- proto_err_o  out  1  sticky flag; set by s_rvalid_i while the FIFO is empty; cleared only by reset

## Operation
- Address-phase FSM states:
  - ARB: selection is free.
  - LOCK_M1 / LOCK_M2: a request was presented without gnt, so the selection is held.
- Selection in ARB:
  - Only one master requesting: select it.
  - Both requesting: select M1 if starve_cnt == STARVE_LIMIT, else M2.
  - Neither requesting: select M1.
- In LOCK_Mx the selection is Mx regardless of the other request.
- Slave payload is always muxed from the selected master.
- s_req_o = selected master's req AND (count < NUM_OUTSTANDING).
- Grants: selected master's gnt = s_gnt_i AND s_req_o; the unselected master's gnt = 0.
- Handshake: s_req_o && s_gnt_i. On a handshake, push the selected ID (0=M1, 1=M2) into the FIFO.
- FSM transitions:
  - ARB -> LOCK_Mx when s_req_o=1, s_gnt_i=0 and Mx is selected.
  - LOCK_Mx -> ARB on a handshake, or when m_x req_i drops (master protocol violation; tolerated, nothing issued).
  - FIFO full while a master requests: stay in ARB (s_req_o=0), so there is no lock.
- Response path:
  - On s_rvalid_i, route rvalid and rdata to the master named by the FIFO head, then pop.
  - The other master gets rvalid=0 and rdata=0.
  - s_rvalid_i with an empty FIFO: drop it, set proto_err_o, leave count unchanged.
- Count:
  - Increments on a handshake, decrements on a valid pop.
  - Both in the same cycle: count unchanged, push and pop both happen.
  - Full is computed from the registered count; there is no same-cycle bypass from a pop.
- starve_cnt (8 bit):
  - Increments, saturating at STARVE_LIMIT, on an M2 handshake while m1_req_i=1.
  - Clears on an M1 handshake, or whenever m1_req_i=0.
- FIFO pointers wrap modulo NUM_OUTSTANDING.

## Timing
- Reset values: FSM=ARB, count=0, FIFO pointers=0, starve_cnt=0, proto_err_o=0, busy_o=0.
- With no master requesting, all handshake outputs and m*_rdata_o are 0.
- Grant is combinational from s_gnt_i, with zero added latency; a back-to-back handshake every cycle is sustainable.
- Response is combinational from s_rvalid_i and s_rdata_i; rvalid can arrive the cycle after its handshake at the earliest.
- Asserting reset mid-transaction discards the FIFO contents and any lock. Responses arriving after reset release count as spurious.

## Test plan
- Single M1 read, gnt same cycle, rvalid 1 cycle later, rdata=0xDEADBEEF -> m1_gnt_o=1 in cycle 0; m1_rvalid_o=1 with rdata 0xDEADBEEF in cycle 1; m2 outputs stay 0; busy_o high for exactly 1 cycle.
- Both request continuously, slave always grants, STARVE_LIMIT=8 -> 8 M2 handshakes, then 1 M1 handshake, repeating; responses are routed in issue order.
- M2 presented with gnt withheld 3 cycles while M1 raises req in cycle 1 -> s_addr_o holds M2's address for all 4 cycles; M2 is granted in cycle 3; M1 is granted in cycle 4.
- NUM_OUTSTANDING=2, slave grants every cycle and delays rvalid 5 cycles -> s_req_o drops after 2 handshakes; reissue happens the cycle after the first rvalid; count never exceeds 2.
- Push and pop in the same cycle at count=1 -> count stays 1; FIFO head advances correctly.
- Spurious s_rvalid_i after reset -> proto_err_o=1 sticky; m1_rvalid_o and m2_rvalid_o both 0.
